// File: rtl/game_io_pkg.sv
// game_io_pkg: register map, field widths and frame register layout for game_io_regs
package game_io_pkg;
    localparam logic [3:0] IO_BASE_DEFAULT = 4'hF;
    localparam int DINO_W  = 10;
    localparam int OBS_W   = 10;
    localparam int SCORE_W = 16;
    localparam int FRAME_W = 16;
    localparam logic [7:0] OFF_DINO_Y     = 8'h00;
    localparam logic [7:0] OFF_OBSTACLE_X = 8'h01;
    localparam logic [7:0] OFF_SCORE      = 8'h02;
    localparam logic [7:0] OFF_CONTROL    = 8'h03;
    localparam logic [7:0] OFF_COMMIT     = 8'h04;
    localparam logic [7:0] OFF_STATUS     = 8'h08;
    localparam logic [7:0] OFF_JUMP_ACK   = 8'h09;
    typedef struct packed {
        logic               game_over;
        logic [SCORE_W-1:0] score;
        logic [OBS_W-1:0]   obstacle_x;
        logic [DINO_W-1:0]  dino_y;
    } frame_regs_t;
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchronizer followed by a consecutive-sample debouncer
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic state_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          state_q, state_d;
    logic          differ, done;
    always_comb begin
        differ  = sync_q[1] != state_q;
        done    = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
        cnt_d   = !differ || done ? '0 : cnt_q + CW'(1);
        state_d = differ && done ? sync_q[1] : state_q;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            state_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end
    assign state_o = state_q;
endmodule

// File: rtl/game_io_regs.sv
// game_io_regs: memory-mapped game display registers with frame-synchronous commit and buttons
module game_io_regs
    import game_io_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 1000000,
    parameter logic [3:0] IO_BASE         = IO_BASE_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wren,
    input  logic [11:0]         addr,
    input  logic [31:0]         data,
    output logic [31:0]         q_io,
    output logic                io_sel,
    input  logic                screen_end,
    input  logic                up,
    input  logic                down,
    output logic [DINO_W-1:0]   dino_y,
    output logic [OBS_W-1:0]    obstacle_x,
    output logic [SCORE_W-1:0]  score,
    output logic                game_over,
    output logic                io_jump,
    output logic                frame_committed
);
    frame_regs_t        shadow_q, shadow_d, active_q, active_d;
    logic               pending_q, pending_d, jump_q, jump_d, committed_q, up_prev_q;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [31:0]        q_q, q_d;
    logic [7:0]         off;
    logic               wr, commit_wr, copy, up_db, down_db;
    logic               unused_data;
    assign unused_data = ^data[31:16];
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk_i(clock), .rst_i(reset), .btn_i(up), .state_o(up_db)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clk_i(clock), .rst_i(reset), .btn_i(down), .state_o(down_db)
    );
    assign io_sel    = addr[11:8] == IO_BASE;
    assign off       = addr[7:0];
    assign wr        = wren && io_sel;
    assign commit_wr = wr && off == OFF_COMMIT;
    // A commit write landing on the frame edge copies immediately.
    assign copy      = screen_end && (pending_q || commit_wr);
    always_comb begin
        shadow_d            = shadow_q;
        shadow_d.dino_y     = wr && off == OFF_DINO_Y ? data[DINO_W-1:0] : shadow_q.dino_y;
        shadow_d.obstacle_x = wr && off == OFF_OBSTACLE_X ? data[OBS_W-1:0] : shadow_q.obstacle_x;
        shadow_d.score      = wr && off == OFF_SCORE ? data[SCORE_W-1:0] : shadow_q.score;
        shadow_d.game_over  = wr && off == OFF_CONTROL ? data[0] : shadow_q.game_over;
        active_d            = copy ? shadow_q : active_q;
        pending_d           = !copy && (pending_q || commit_wr);
        jump_d              = (up_db && !up_prev_q) || (jump_q && !(wr && off == OFF_JUMP_ACK));
        frame_d             = frame_q + FRAME_W'(screen_end);
        q_d = !io_sel                ? '0
            : off == OFF_DINO_Y      ? 32'(shadow_q.dino_y)
            : off == OFF_OBSTACLE_X  ? 32'(shadow_q.obstacle_x)
            : off == OFF_SCORE       ? 32'(shadow_q.score)
            : off == OFF_CONTROL     ? 32'(shadow_q.game_over)
            : off == OFF_STATUS      ? {frame_q, 13'b0, pending_q, down_db, jump_q}
            : '0;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_q    <= '0;
            active_q    <= '0;
            pending_q   <= 1'b0;
            jump_q      <= 1'b0;
            committed_q <= 1'b0;
            up_prev_q   <= 1'b0;
            frame_q     <= '0;
            q_q         <= '0;
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            jump_q      <= jump_d;
            committed_q <= copy;
            up_prev_q   <= up_db;
            frame_q     <= frame_d;
            q_q         <= q_d;
        end
    end
    assign dino_y          = active_q.dino_y;
    assign obstacle_x      = active_q.obstacle_x;
    assign score           = active_q.score;
    assign game_over       = active_q.game_over;
    assign io_jump         = jump_q;
    assign frame_committed = committed_q;
    assign q_io            = q_q;
endmodule

// File: tb/tb_game_io_regs.sv
// tb_game_io_regs: randomized scoreboard bench with a behavioural register/button model
module tb_game_io_regs;
    localparam int D = 4;
    logic        clock = 1'b0;
    logic        reset, wren, screen_end, up, down;
    logic [11:0] addr;
    logic [31:0] data, q_io;
    logic        io_sel, game_over, io_jump, frame_committed;
    logic [9:0]  dino_y, obstacle_x;
    logic [15:0] score;

    game_io_regs #(.DEBOUNCE_CYCLES(D)) dut (
        .clock(clock), .reset(reset), .wren(wren), .addr(addr), .data(data),
        .q_io(q_io), .io_sel(io_sel), .screen_end(screen_end), .up(up), .down(down),
        .dino_y(dino_y), .obstacle_x(obstacle_x), .score(score), .game_over(game_over),
        .io_jump(io_jump), .frame_committed(frame_committed)
    );

    always #5 clock = ~clock;

    logic [31:0] sh[4], act[4];
    bit          pend, jmp, rise_p, fc, dbu, dbd, chk_rd, mon_en;
    logic [15:0] frm;
    logic [63:0] hu, hd;
    logic [31:0] rdq[$];
    logic [36:0] cq[$];
    int          checks = 0, passed = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) $display("FAIL %s: got %0h expected %0h", n, a, e);
        else passed++;
    endtask

    function automatic logic [31:0] fmask(input int i);
        return i == 2 ? 32'hFFFF : i == 3 ? 32'h1 : 32'h3FF;
    endfunction

    function automatic logic [36:0] pack(input logic [31:0] r[4]);
        return {r[3][0], r[2][15:0], r[1][9:0], r[0][9:0]};
    endfunction

    task automatic model_edge(input bit rd);
        logic [7:0]  off;
        logic [31:0] e;
        bit          sel, wr, cw, cp, fu, fd;
        sel = addr[11:8] == 4'hF;
        off = addr[7:0];
        wr  = wren && sel;
        if (reset) begin
            foreach (sh[i]) begin sh[i] = 0; act[i] = 0; end
            pend = 0; jmp = 0; rise_p = 0; fc = 0; dbu = 0; dbd = 0; frm = 0; hu = 0; hd = 0;
            if (rd) rdq.push_back(0);
        end else begin
            if (rd) begin
                e = !sel ? 32'h0 : off < 4 ? sh[off[1:0]] : off == 8 ? {frm, 13'b0, pend, dbd, jmp} : 32'h0;
                rdq.push_back(e);
            end
            cw = wr && off == 4;
            cp = screen_end && (pend || cw);
            if (cp) begin
                foreach (act[i]) act[i] = sh[i];
                cq.push_back(pack(sh));
            end
            fc   = cp;
            pend = !cp && (pend || cw);
            if (wr && off < 4) sh[off[1:0]] = data & fmask(int'(off));
            frm += 16'(screen_end);
            jmp = rise_p || (jmp && !(wr && off == 9));
            // a button level is adopted once D consecutive synchronized samples disagree with it
            fu = hu[D:1] == {D{~dbu}};
            fd = hd[D:1] == {D{~dbd}};
            dbu ^= fu;
            dbd ^= fd;
            rise_p = fu && dbu;
            hu = {hu[62:0], up};
            hd = {hd[62:0], down};
        end
        chk_rd = rd;
    endtask

    task automatic step(input bit we, input logic [11:0] a, input logic [31:0] d, input bit se, input bit rd, input bit rst);
        wren = we; addr = a; data = d; screen_end = se; reset = rst;
        @(posedge clock);
        model_edge(rd);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 12'h000, 0, 0, 0, 0);
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            chk("io_sel", io_sel, addr[11:8] == 4'hF);
            chk("frame_committed", frame_committed, fc);
            chk("active_outputs", {game_over, score, obstacle_x, dino_y}, pack(act));
            chk("io_jump", io_jump, jmp);
            if (frame_committed) begin
                if (cq.size() == 0) begin
                    checks++;
                    $display("FAIL commit_unexpected: frame_committed=1 required 0");
                end else chk("committed_frame", {game_over, score, obstacle_x, dino_y}, cq.pop_front());
            end
            if (chk_rd) begin
                if (rdq.size() == 0) begin
                    checks++;
                    $display("FAIL read_unexpected: q_io=%0h with no expected read", q_io);
                end else chk("q_io", q_io, rdq.pop_front());
            end
        end
    end

    initial begin
        up = 0; down = 0;
        step(0, 12'h000, 0, 0, 0, 1);
        step(0, 12'h000, 0, 0, 0, 1);
        mon_en = 1;
        chk("reset_q_io", q_io, 0);
        chk("reset_outputs", {game_over, score, obstacle_x, dino_y}, 0);
        chk("reset_jump", io_jump, 0);

        step(1, 12'hF00, 123, 0, 0, 0);
        step(1, 12'hF04, $urandom, 0, 0, 0);
        step(0, 12'h000, 0, 1, 0, 0);
        chk("commit_dino_y", dino_y, 123);
        chk("commit_pulse", frame_committed, 1);
        idle(1);
        chk("commit_pulse_end", frame_committed, 0);

        step(1, 12'hF01, 500, 0, 0, 0);
        step(0, 12'h000, 0, 1, 0, 0);
        step(0, 12'h000, 0, 1, 0, 0);
        chk("nocommit_obstacle_x", obstacle_x, 0);
        step(0, 12'hF01, 0, 0, 1, 0);
        chk("shadow_readback", q_io, 500);

        up = 1;
        idle(D + 3);
        chk("jump_set", io_jump, 1);
        step(1, 12'hF09, 0, 0, 0, 0);
        chk("jump_ack", io_jump, 0);
        up = 0; idle(2); up = 1; idle(10);
        chk("glitch_low_no_edge", io_jump, 0);
        up = 0; idle(10);
        up = 1; idle(2); up = 0; idle(10);
        chk("glitch_high_no_edge", io_jump, 0);

        up = 1;
        idle(D + 2);
        chk("jump_before_edge", io_jump, 0);
        step(1, 12'hF09, 0, 0, 0, 0);
        chk("jump_set_beats_ack", io_jump, 1);
        step(1, 12'hF09, 0, 0, 0, 0);
        chk("jump_ack_again", io_jump, 0);
        up = 0;

        repeat (400) begin
            logic [11:0] a;
            a = {($urandom_range(0, 7) == 0) ? 4'hE : 4'hF, 4'h0, 4'($urandom_range(0, 11))};
            if ($urandom_range(0, 11) == 0) up = ~up;
            if ($urandom_range(0, 11) == 0) down = ~down;
            step($urandom_range(0, 1) == 1, a, $urandom, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, 0);
        end
        up = 0; down = 0;

        step(1, 12'hF00, 77, 0, 0, 0);
        step(1, 12'hF02, 999, 0, 0, 0);
        step(1, 12'hF04, 0, 0, 0, 0);
        step(0, 12'h000, 0, 0, 0, 1);
        step(0, 12'h000, 0, 1, 0, 0);
        chk("reset_drops_commit", {game_over, score, obstacle_x, dino_y}, 0);
        chk("reset_no_pulse", frame_committed, 0);
        step(0, 12'hF00, 0, 0, 1, 0);
        chk("reset_clears_shadow", q_io, 0);

        step(0, 12'h000, 0, 0, 0, 1);
        repeat (65535) step(0, 12'h000, 0, 1, 0, 0);
        step(0, 12'hF08, 0, 0, 1, 0);
        chk("frame_ffff", q_io[31:16], 16'hFFFF);
        step(0, 12'h000, 0, 1, 0, 0);
        step(0, 12'hF08, 0, 0, 1, 0);
        chk("frame_wrap", q_io[31:16], 16'h0000);

        idle(3);
        chk("read_queue_drained", rdq.size(), 0);
        chk("commit_queue_drained", cq.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
